// File: rtl/sm_pkg.sv
// Shared types and helpers for the signed-magnitude division sequencer.
// Provides the FSM state enum, field helpers and the result packer.
package sm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } state_t;

    localparam int PACK_MAX = 64;

    function automatic int sign_idx(input int w);
        return w - 1;
    endfunction

    function automatic int mag_bits(input int w);
        return w - 1;
    endfunction

    // Sign lands at out_w-1, magnitude at [mag_w-1:0], all other bits zero.
    function automatic logic [PACK_MAX-1:0] sm_pack(
        input logic                sign,
        input logic [PACK_MAX-1:0] mag,
        input int                  out_w,
        input int                  mag_w
    );
        logic [PACK_MAX-1:0] mask;
        logic [PACK_MAX-1:0] sbit;
        mask = (PACK_MAX'(1) << mag_w) - PACK_MAX'(1);
        sbit = PACK_MAX'(sign) << (out_w - 1);
        return (mag & mask) | sbit;
    endfunction

endpackage

// File: rtl/sm_div_step.sv
// One combinational restoring-division step on MAG-bit magnitudes.
// Ports: rem_acc/quo_acc/divisor in, rem_next/quo_next out.
module sm_div_step #(
    parameter int MAG = 2
) (
    input  logic [MAG-1:0] rem_acc,
    input  logic [MAG-1:0] quo_acc,
    input  logic [MAG-1:0] divisor,
    output logic [MAG-1:0] rem_next,
    output logic [MAG-1:0] quo_next
);

    logic [MAG:0] rem_sh;
    logic [MAG:0] trial;
    logic         ge;

    // rem_acc < divisor always holds, so MAG+1 bits are enough for
    // the MSB of trial to act as its sign.
    always_comb begin
        rem_sh   = {rem_acc, quo_acc[MAG-1]};
        trial    = rem_sh - {1'b0, divisor};
        ge       = ~trial[MAG];
        rem_next = ge ? trial[MAG-1:0] : rem_sh[MAG-1:0];
        quo_next = MAG'({quo_acc, ge});
    end

endmodule

// File: rtl/sm_div_seq.sv
// Multi-cycle signed-magnitude divider: quotient and remainder with start/done.
// Ports: clk, rst, start, numerator, denominator -> busy, done, quotient, remainder, divbyzero, zero.
module sm_div_seq
    import sm_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int OUT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     numerator,
    input  logic [WIDTH-1:0]     denominator,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] quotient,
    output logic [OUT_WIDTH-1:0] remainder,
    output logic                 divbyzero,
    output logic                 zero
);

    localparam int MAG = mag_bits(WIDTH);
    localparam int SI  = sign_idx(WIDTH);
    localparam int CW  = (MAG > 1) ? $clog2(MAG) : 1;

    state_t         state;
    logic [MAG-1:0] rem_acc;
    logic [MAG-1:0] quo_acc;
    logic [MAG-1:0] den_mag;
    logic [MAG-1:0] rem_nxt;
    logic [MAG-1:0] quo_nxt;
    logic [CW-1:0]  cnt;
    logic           sign_q;
    logic           num_zero;
    logic [MAG-1:0] num_mag;
    logic [MAG-1:0] den_in;

    assign num_mag = numerator[MAG-1:0];
    assign den_in  = denominator[MAG-1:0];

    sm_div_step #(
        .MAG (MAG)
    ) u_step (
        .rem_acc  (rem_acc),
        .quo_acc  (quo_acc),
        .divisor  (den_mag),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            divbyzero <= 1'b0;
            zero      <= 1'b0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            den_mag   <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            num_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign_q   <= numerator[SI] ^ denominator[SI];
                        num_zero <= (num_mag == '0);
                        den_mag  <= den_in;
                        if (den_in == '0) begin
                            // Negative zero divisor also lands here.
                            state     <= FINISH;
                            done      <= 1'b1;
                            divbyzero <= 1'b1;
                            zero      <= 1'b0;
                            quotient  <= '0;
                            remainder <= OUT_WIDTH'(sm_pack(numerator[SI], '0,
                                                            OUT_WIDTH, MAG));
                        end else begin
                            state   <= DIVIDE;
                            busy    <= 1'b1;
                            rem_acc <= '0;
                            quo_acc <= num_mag;
                            cnt     <= CW'(MAG - 1);
                        end
                    end
                end
                DIVIDE: begin
                    rem_acc <= rem_nxt;
                    quo_acc <= quo_nxt;
                    if (cnt == '0) begin
                        state     <= FINISH;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        divbyzero <= 1'b0;
                        zero      <= num_zero;
                        quotient  <= OUT_WIDTH'(sm_pack(sign_q, PACK_MAX'(quo_nxt),
                                                        OUT_WIDTH, MAG));
                        remainder <= OUT_WIDTH'(sm_pack(sign_q, PACK_MAX'(rem_nxt),
                                                        OUT_WIDTH, MAG));
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_div_seq.sv
// Self-checking bench for sm_div_seq with a result scoreboard.
// Directed cases from the test plan followed by randomized operations.
module tb_sm_div_seq;

    localparam int WIDTH     = 3;
    localparam int OUT_WIDTH = 5;
    localparam int MAG       = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     numerator;
    logic [WIDTH-1:0]     denominator;
    logic                 busy;
    logic                 done;
    logic [OUT_WIDTH-1:0] quotient;
    logic [OUT_WIDTH-1:0] remainder;
    logic                 divbyzero;
    logic                 zero;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] q;
        logic [OUT_WIDTH-1:0] r;
        logic                 dbz;
        logic                 z;
        int                   lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sm_div_seq #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .numerator   (numerator),
        .denominator (denominator),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .divbyzero   (divbyzero),
        .zero        (zero)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] n, input logic [2:0] d);
        exp_t       e;
        logic [1:0] nm;
        logic [1:0] dm;
        logic [1:0] qm;
        logic [1:0] rm;
        logic       s;
        e  = '0;
        nm = n[1:0];
        dm = d[1:0];
        s  = n[2] ^ d[2];
        if (dm == 2'd0) begin
            e.q   = 5'b00000;
            e.r   = {n[2], 4'b0000};
            e.dbz = 1'b1;
            e.z   = 1'b0;
            e.lat = 1;
        end else begin
            qm    = nm / dm;
            rm    = nm % dm;
            e.q   = {s, 2'b00, qm};
            e.r   = {s, 2'b00, rm};
            e.dbz = 1'b0;
            e.z   = (nm == 2'd0);
            e.lat = MAG + 1;
        end
        return e;
    endfunction

    task automatic issue(input logic [2:0] n, input logic [2:0] d);
        start       = 1'b1;
        numerator   = n;
        denominator = d;
        sb.push_back(model(n, d));
    endtask

    // Called at the negedge of cycle c0 after the accepting edge.
    task automatic wait_done(input int c0);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int c = c0; c <= 20 && !seen; c++) begin
                if (c > c0) @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    chk("latency", 32'(c), 32'(e.lat));
                    chk("quotient", 32'(quotient), 32'(e.q));
                    chk("remainder", 32'(remainder), 32'(e.r));
                    chk("divbyzero", 32'(divbyzero), 32'(e.dbz));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("busy_at_done", 32'(busy), 32'd0);
                end else begin
                    chk("busy", 32'(busy), 32'(c < e.lat));
                end
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic hold(input int n);
        logic [OUT_WIDTH-1:0] q0;
        logic [OUT_WIDTH-1:0] r0;
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd0);
            chk("hold_q", 32'(quotient), 32'(q0));
            chk("hold_r", 32'(remainder), 32'(r0));
        end
    endtask

    task automatic run_op(input logic [2:0] n, input logic [2:0] d);
        issue(n, d);
        @(negedge clk);
        start       = 1'b0;
        numerator   = ~n;
        denominator = ~d;
        wait_done(1);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        numerator   = '0;
        denominator = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(divbyzero), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'b011, 3'b010);
        @(negedge clk);
        start = 1'b0;
        wait_done(1);
        hold(2);

        run_op(3'b111, 3'b001);
        run_op(3'b110, 3'b100);
        run_op(3'b100, 3'b011);

        // Second start while busy must be dropped.
        issue(3'b011, 3'b010);
        @(negedge clk);
        start       = 1'b1;
        numerator   = 3'b010;
        denominator = 3'b001;
        chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(2);
        hold(4);

        // Reset in the middle of an operation.
        issue(3'b011, 3'b011);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_q", 32'(quotient), 32'd0);
        chk("mid_rst_r", 32'(remainder), 32'd0);
        chk("mid_rst_flags", 32'({divbyzero, zero}), 32'd0);
        @(negedge clk);
        run_op(3'b010, 3'b001);

        // Start held through FINISH: taken only once back in IDLE.
        issue(3'b011, 3'b001);
        @(negedge clk);
        start = 1'b0;
        wait_done(1);
        issue(3'b011, 3'b010);
        @(negedge clk);
        chk("fin_idle_busy", 32'(busy), 32'd0);
        chk("fin_idle_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done(1);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_op(3'($urandom_range(7)), 3'($urandom_range(7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
